// File: rtl/vram_scanner.sv
// vram_scanner: VGA raster generator that reads video memory back out.
// Generates a 25 MHz pixel enable from the 50 MHz clock, walks h/v counters,
// issues sequential read addresses, and returns colour with hsync/vsync/blank
// aligned two pixel ticks after the counter value that produced them.
// Raises out_cont_signal at vblank entry so the painter can redraw.
// Optional build macro VRAM_SCANNER_QUAD_SCALE_EN: quarter-resolution memory
// (each stored pixel shown as a 4x4 block); default build is full resolution.
module vram_scanner #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int ADDR_BITS = 19
) (
  input  logic                 Clck,
  input  logic                 Reset,
  output logic [ADDR_BITS-1:0] read_address,
  input  logic [2:0]           read_color,
  output logic [2:0]           vga_color,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_blank_n,
  output logic                 pixel_tick,
  output logic                 out_cont_signal,
  input  logic                 next_out_cont_signal
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOTAL + 1);
  localparam int V_W      = $clog2(V_TOTAL + 1);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef enum logic {IDLE = 1'b0, READY = 1'b1} state_t;

  logic [H_W-1:0]  h_cnt;
  logic [V_W-1:0]  v_cnt;
  logic            h_last;
  logic            v_last;
  logic            active;
  logic            hsync_now;
  logic            vsync_now;
  logic            vblank_entry;

  logic            vld_p1;
  logic            hsync_p1;
  logic            vsync_p1;

  logic [2:0]      color_p2;
  logic            hsync_p2;
  logic            vsync_p2;
  logic            vld_p2;

  state_t          state;
  state_t          state_next;

  // Memory address of the pixel under the raster; wraps modulo 2^ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] pixel_addr(input logic [H_W-1:0] h,
                                                      input logic [V_W-1:0] v);
`ifdef VRAM_SCANNER_QUAD_SCALE_EN
    return ADDR_BITS'(v >> 2) * ADDR_BITS'(H_ACTIVE / 4) + ADDR_BITS'(h >> 2);
`else
    return ADDR_BITS'(v) * ADDR_BITS'(H_ACTIVE) + ADDR_BITS'(h);
`endif
  endfunction

  assign h_last       = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last       = (v_cnt == V_W'(V_TOTAL - 1));
  assign active       = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
  assign hsync_now    = !((h_cnt >= H_W'(HS_START)) && (h_cnt < H_W'(HS_END)));
  assign vsync_now    = !((v_cnt >= V_W'(VS_START)) && (v_cnt < V_W'(VS_END)));
  // The tick on which the counters step from the last active line into vblank.
  assign vblank_entry = pixel_tick && h_last && (v_cnt == V_W'(V_ACTIVE - 1));

  // Divide-by-two pixel enable.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) pixel_tick <= 1'b0;
    else        pixel_tick <= ~pixel_tick;
  end

  // Raster position counters, advancing once per pixel tick.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // ---- stage 1: read address and timing flags; address holds in blanking ----
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      read_address <= '0;
      vld_p1       <= 1'b0;
      hsync_p1     <= 1'b1;
      vsync_p1     <= 1'b1;
    end else if (pixel_tick) begin
      vld_p1   <= active;
      hsync_p1 <= hsync_now;
      vsync_p1 <= vsync_now;
      if (active) read_address <= pixel_addr(h_cnt, v_cnt);
    end
  end

  // ---- stage 2: capture memory data (valid one Clck after the address) ----
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      color_p2 <= 3'd0;
      hsync_p2 <= 1'b1;
      vsync_p2 <= 1'b1;
      vld_p2   <= 1'b0;
    end else if (pixel_tick) begin
      color_p2 <= vld_p1 ? read_color : 3'd0;
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
      vld_p2   <= vld_p1;
    end
  end

  assign vga_color   = color_p2;
  assign vga_hsync   = hsync_p2;
  assign vga_vsync   = vsync_p2;
  assign vga_blank_n = vld_p2;

  // Continuation state register.
  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: acknowledge takes priority over a coincident vblank entry.
  always_comb begin
    state_next = state;
    if (next_out_cont_signal)  state_next = IDLE;
    else if (vblank_entry)     state_next = READY;
  end

  // Continuation output is high for as long as the frame is unacknowledged.
  always_comb begin
    out_cont_signal = 1'b0;
    if (state == READY) out_cont_signal = 1'b1;
  end

endmodule

// File: tb/tb_vram_scanner.sv
// Testbench for vram_scanner: a small-geometry instance checked every Clck
// against a queue of expected pixel outputs, plus a default-geometry instance
// checked at selected raster points of the first lines.
module tb_vram_scanner;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int AB = 7;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = 2 * HT * VT;
  localparam logic [5:0] RST_EXP = 6'b011000;  // {blank_n, vsync, hsync, color}

`ifdef VRAM_SCANNER_QUAD_SCALE_EN
  localparam int D_C5 = 1, D_A01 = 0, D_A11 = 0, D_C11 = 0, D_A33 = 0, D_A44 = 161;
`else
  localparam int D_C5 = 5, D_A01 = 640, D_A11 = 641, D_C11 = 1, D_A33 = 1923, D_A44 = 2564;
`endif

  logic Clck = 1'b0;
  logic Reset;
  logic ack;
  logic ack_d;

  logic [AB-1:0] ra_s;
  logic [2:0]    rc_s = 3'd0;
  logic [2:0]    col_s;
  logic          hs_s, vs_s, bl_s, pt_s, oc_s;

  logic [18:0]   ra_d;
  logic [2:0]    rc_d = 3'd0;
  logic [2:0]    col_d;
  logic          hs_d, vs_d, bl_d, pt_d, oc_d;

  vram_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .ADDR_BITS(AB)
  ) dut (
    .Clck(Clck), .Reset(Reset), .read_address(ra_s), .read_color(rc_s),
    .vga_color(col_s), .vga_hsync(hs_s), .vga_vsync(vs_s), .vga_blank_n(bl_s),
    .pixel_tick(pt_s), .out_cont_signal(oc_s), .next_out_cont_signal(ack)
  );

  vram_scanner dut_d (
    .Clck(Clck), .Reset(Reset), .read_address(ra_d), .read_color(rc_d),
    .vga_color(col_d), .vga_hsync(hs_d), .vga_vsync(vs_d), .vga_blank_n(bl_d),
    .pixel_tick(pt_d), .out_cont_signal(oc_d), .next_out_cont_signal(ack_d)
  );

  always #5 Clck = ~Clck;

  // Memory models: colour is the low three address bits, one Clck late.
  always @(posedge Clck) rc_s <= ra_s[2:0];
  always @(posedge Clck) rc_d <= ra_d[2:0];

  int total = 0;
  int bad   = 0;

  bit            m_tick;
  int            mh, mv;
  logic [AB-1:0] m_addr;
  bit            m_state;
  logic [5:0]    last_exp;
  logic [5:0]    sb[$];
  int            rises;
  logic          prev_oc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [AB-1:0] m_pixel_addr(input int h, input int v);
`ifdef VRAM_SCANNER_QUAD_SCALE_EN
    return AB'((v / 4) * (HA / 4) + (h / 4));
`else
    return AB'(v * HA + h);
`endif
  endfunction

  task automatic model_reset();
    m_tick   = 1'b0;
    mh       = 0;
    mv       = 0;
    m_addr   = '0;
    m_state  = 1'b0;
    sb.delete();
    sb.push_back(RST_EXP);
    last_exp = RST_EXP;
    prev_oc  = 1'b0;
  endtask

  // One Clck of the small instance: update the model, then compare all outputs.
  task automatic step();
    logic       a, wt, act, hsx, vsx;
    @(posedge Clck);
    a  = ack;
    wt = m_tick;
    if (a) m_state = 1'b0;
    else if (wt && mh == HT - 1 && mv == VA - 1) m_state = 1'b1;
    if (wt) begin
      if (sb.size() > 0) last_exp = sb.pop_front();
      act = (mh < HA) && (mv < VA);
      if (act) m_addr = m_pixel_addr(mh, mv);
      hsx = !((mh >= HA + HF) && (mh < HA + HF + HS));
      vsx = !((mv >= VA + VF) && (mv < VA + VF + VS));
      sb.push_back({act, vsx, hsx, act ? m_addr[2:0] : 3'd0});
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    m_tick = !m_tick;
    #1;
    check("pixel_tick", pt_s, m_tick);
    check("cont", oc_s, m_state);
    check("read_address", ra_s, m_addr);
    check("color", col_s, last_exp[2:0]);
    check("hsync", hs_s, last_exp[3]);
    check("vsync", vs_s, last_exp[4]);
    check("blank_n", bl_s, last_exp[5]);
    if (oc_s && !prev_oc) rises++;
    prev_oc = oc_s;
  endtask

  task automatic check_reset_values();
    check("rst_pixel_tick", pt_s, 0);
    check("rst_addr", ra_s, 0);
    check("rst_color", col_s, 0);
    check("rst_hsync", hs_s, 1);
    check("rst_vsync", vs_s, 1);
    check("rst_blank_n", bl_s, 0);
    check("rst_cont", oc_s, 0);
    check("rst_d_addr", ra_d, 0);
    check("rst_d_hsync", hs_d, 1);
    check("rst_d_vsync", vs_d, 1);
  endtask

  initial begin
    int   hs_fall1, hs_rise1, hs_fall2, n;
    logic prev_hs_d;
    Reset = 1'b0;
    ack   = 1'b0;
    ack_d = 1'b0;
    hs_fall1 = 0; hs_rise1 = 0; hs_fall2 = 0;
    prev_hs_d = 1'b1;
    rises = 0;
    model_reset();

    repeat (3) @(posedge Clck);
    #1;
    check_reset_values();
    #2;
    Reset = 1'b1;
    model_reset();

    // First lines of the default geometry; small instance runs ~9 frames unacked.
    for (int e = 1; e <= 6420; e++) begin
      step();
      check("d_vsync_high", vs_d, 1);
      if (hs_fall1 == 0 && prev_hs_d && !hs_d) hs_fall1 = e;
      else if (hs_fall1 != 0 && hs_rise1 == 0 && !prev_hs_d && hs_d) hs_rise1 = e;
      else if (hs_rise1 != 0 && hs_fall2 == 0 && prev_hs_d && !hs_d) hs_fall2 = e;
      prev_hs_d = hs_d;
      case (e)
        14:   begin check("d_color_5_0", col_d, D_C5); check("d_blank_5_0", bl_d, 1); end
        1404: begin check("d_color_700_0", col_d, 0); check("d_blank_700_0", bl_d, 0); end
        1602: check("d_addr_0_1", ra_d, D_A01);
        1604: begin check("d_color_0_1", col_d, 0); check("d_addr_1_1", ra_d, D_A11); end
        1606: check("d_color_1_1", col_d, D_C11);
        4808: check("d_addr_3_3", ra_d, D_A33);
        6410: check("d_addr_4_4", ra_d, D_A44);
        6412: check("d_color_4_4", col_d, D_A44 % 8);
        default: ;
      endcase
    end
    check("d_hsync_fall", hs_fall1, 2 * 656 + 4);
    check("d_hsync_width", hs_rise1 - hs_fall1, 2 * 96);
    check("d_line_period", hs_fall2 - hs_fall1, 2 * 800);
    check("single_rise_no_ack", rises, 1);

    // One-Clck acknowledge drops the request; it returns at the next vblank.
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_drop", oc_s, 0);
    for (int i = 0; i < FRAME_CLK + 4; i++) step();
    check("rise_after_ack", rises, 2);

    // Acknowledge on the same edge as vblank entry: acknowledge wins.
    n = 0;
    while (!(m_tick && mh == HT - 1 && mv == VA - 1) && n < 2 * FRAME_CLK) begin
      step();
      n++;
    end
    check("vblank_found", (n < 2 * FRAME_CLK), 1);
    check("pre_coincident_cont", oc_s, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("coincident_cont", oc_s, 0);
    for (int i = 0; i < FRAME_CLK; i++) step();
    check("rise_after_coincident", rises, 3);

    // Asynchronous reset mid-line while the request is pending.
    n = 0;
    while (!(mh == 10 && mv == 5) && n < 2 * FRAME_CLK) begin
      step();
      n++;
    end
    check("midline_found", (n < 2 * FRAME_CLK), 1);
    check("pre_reset_cont", oc_s, 1);
    #2;
    Reset = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge Clck);
    #3;
    Reset = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME_CLK + 20; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
